// File: rtl/regread_hazard_unit.sv
// Purpose : ID-stage register-read decoder plus in-flight write scoreboard; raises stall on RAW hazards.
// Latency : decode/stall/issue/forward-select are combinational; counters are registered (1 cycle).
// Backpressure: stall holds IF/ID and injects a bubble into scoreboard stage 0; flush overrides stall.
//
// Optional feature macro: REGREAD_FORWARD_EN
//    defined   -> forwarding rules (only a load in stage 0 stalls), fwd_*_sel driven
//    undefined -> stall-only rules, fwd_*_sel tied to 0, no forwarding comparators
//
// Ports:
//    clk, rst_n                 clock, asynchronous active-low reset
//    id_valid                   ID-stage instruction valid
//    id_op, id_funct            MIPS opcode / funct fields
//    id_rs, id_rt, id_rd        register fields
//    flush                      kill ID instruction and scoreboard stage 0
//    read_rs, read_rt           source-use decode
//    stall, issue               hazard stall, instruction leaves ID this cycle
//    fwd_rs_sel, fwd_rt_sel     0 = register file, k = scoreboard stage k-1
//    inflight_cnt               number of valid scoreboard entries
//    stall_cnt                  saturating stall-cycle counter

module regread_hazard_unit #(
   parameter int WB_STAGES   = 3,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   id_valid,
   input  logic [5:0]             id_op,
   input  logic [5:0]             id_funct,
   input  logic [4:0]             id_rs,
   input  logic [4:0]             id_rt,
   input  logic [4:0]             id_rd,
   input  logic                   flush,
   output logic                   read_rs,
   output logic                   read_rt,
   output logic                   stall,
   output logic                   issue,
   output logic [3:0]             fwd_rs_sel,
   output logic [3:0]             fwd_rt_sel,
   output logic [3:0]             inflight_cnt,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_COP0  = 6'b010000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_SRA  = 6'h03;
   localparam logic [5:0] F_JR   = 6'h08;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2a;
   localparam logic [5:0] F_SLTU = 6'h2b;

   typedef struct packed {
      logic       vld;
      logic [4:0] dst;
      logic       is_load;
   } sb_entry_t;

   sb_entry_t              r_sb     [WB_STAGES];
   sb_entry_t              w_sb_nxt [WB_STAGES];
   logic [3:0]             r_inflight_cnt;
   logic [3:0]             w_inflight_nxt;
   logic [STALL_CNT_W-1:0] r_stall_cnt;

   logic       w_read_rs, w_read_rt, w_writes, w_is_load;
   logic [4:0] w_dst;
   logic       w_rs_chk, w_rt_chk;
   logic       w_hit_rs, w_hit_rt;
   logic       w_stall, w_issue;
   logic       w_sb_unused;

   // ---------------------------------------------------------------- decode
   always_comb begin
      w_read_rs = 1'b0;
      w_read_rt = 1'b0;
      w_writes  = 1'b0;
      w_is_load = 1'b0;
      w_dst     = id_rt;
      case (id_op)
         OP_RTYPE: begin
            w_dst = id_rd;
            case (id_funct)
               F_ADD, F_ADDU, F_SUB, F_AND, F_OR, F_NOR, F_SLT, F_SLTU: begin
                  w_read_rs = 1'b1;
                  w_read_rt = 1'b1;
                  w_writes  = 1'b1;
               end
               F_SLL, F_SRL, F_SRA: begin
                  w_read_rt = 1'b1;
                  w_writes  = 1'b1;
               end
               F_JR: begin
                  w_read_rs = 1'b1;
               end
               default: begin
                  w_writes = 1'b0;
               end
            endcase
         end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI: begin
            w_read_rs = 1'b1;
            w_writes  = 1'b1;
         end
         OP_LW: begin
            w_read_rs = 1'b1;
            w_writes  = 1'b1;
            w_is_load = 1'b1;
         end
         OP_BEQ, OP_BNE, OP_SW: begin
            w_read_rs = 1'b1;
            w_read_rt = 1'b1;
         end
         OP_COP0: begin
            w_read_rt = 1'b1;
         end
         default: begin
            w_writes = 1'b0;
         end
      endcase
   end

   // $0 is hard-wired, so it never creates a dependency.
   assign w_rs_chk = w_read_rs && (id_rs != 5'd0);
   assign w_rt_chk = w_read_rt && (id_rt != 5'd0);

   // ---------------------------------------------------------------- hazard
   // The last stage writes the register file write-before-read, so only
   // stages 0..WB_STAGES-2 are compared.
`ifdef REGREAD_FORWARD_EN
   logic [3:0] w_rs_sel, w_rt_sel;

   // Walk oldest to youngest so the youngest match wins. Only a load that
   // is still in stage 0 has no data to forward yet.
   always_comb begin
      w_hit_rs = 1'b0;
      w_hit_rt = 1'b0;
      w_rs_sel = 4'd0;
      w_rt_sel = 4'd0;
      for (int i = WB_STAGES - 2; i >= 0; i--) begin
         if (r_sb[i].vld && (r_sb[i].dst == id_rs)) begin
            w_rs_sel = 4'(i + 1);
            w_hit_rs = r_sb[i].is_load && (i == 0);
         end
         if (r_sb[i].vld && (r_sb[i].dst == id_rt)) begin
            w_rt_sel = 4'(i + 1);
            w_hit_rt = r_sb[i].is_load && (i == 0);
         end
      end
   end

   assign fwd_rs_sel = w_rs_chk ? w_rs_sel : 4'd0;
   assign fwd_rt_sel = w_rt_chk ? w_rt_sel : 4'd0;
`else
   always_comb begin
      w_hit_rs = 1'b0;
      w_hit_rt = 1'b0;
      for (int i = 0; i < WB_STAGES - 1; i++) begin
         if (r_sb[i].vld && (r_sb[i].dst == id_rs)) w_hit_rs = 1'b1;
         if (r_sb[i].vld && (r_sb[i].dst == id_rt)) w_hit_rt = 1'b1;
      end
   end

   assign fwd_rs_sel = 4'd0;
   assign fwd_rt_sel = 4'd0;
`endif

   // flush has priority: it masks stall and blocks issue.
   assign w_stall = id_valid && !flush && ((w_rs_chk && w_hit_rs) || (w_rt_chk && w_hit_rt));
   assign w_issue = id_valid && !w_stall && !flush;

   // ------------------------------------------------------------ scoreboard
   // Stage 0 takes a bubble on stall/flush via w_issue. A flush also kills
   // the entry currently in stage 0 instead of letting it advance.
   always_comb begin
      for (int i = 0; i < WB_STAGES; i++) begin
         w_sb_nxt[i] = '0;
      end
      w_sb_nxt[0].vld     = w_issue && w_writes && (w_dst != 5'd0);
      w_sb_nxt[0].dst     = w_dst;
      w_sb_nxt[0].is_load = w_is_load;
      for (int i = 1; i < WB_STAGES; i++) begin
         w_sb_nxt[i] = r_sb[i-1];
         if ((i == 1) && flush) w_sb_nxt[i].vld = 1'b0;
      end
      w_inflight_nxt = 4'd0;
      for (int i = 0; i < WB_STAGES; i++) begin
         w_inflight_nxt = w_inflight_nxt + {3'd0, w_sb_nxt[i].vld};
      end
   end

   // Fields of the retiring stage (and is_load in stall-only builds) have no
   // reader; fold them here so they do not look like dangling logic.
   always_comb begin
      w_sb_unused = 1'b0;
      for (int i = 0; i < WB_STAGES; i++) begin
         w_sb_unused = w_sb_unused ^ (^r_sb[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < WB_STAGES; i++) begin
            r_sb[i] <= '0;
         end
         r_inflight_cnt <= 4'd0;
         r_stall_cnt    <= '0;
      end else begin
         for (int i = 0; i < WB_STAGES; i++) begin
            r_sb[i] <= w_sb_nxt[i];
         end
         r_inflight_cnt <= w_inflight_nxt;
         if (w_stall && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
      end
   end

   assign read_rs      = w_read_rs;
   assign read_rt      = w_read_rt;
   assign stall        = w_stall;
   assign issue        = w_issue;
   assign inflight_cnt = r_inflight_cnt;
   assign stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_regread_hazard_unit.sv
// Purpose : directed self-checking bench for regread_hazard_unit (WB_STAGES=3, plus a
//           4-bit stall counter instance and a WB_STAGES=1 instance sharing the same inputs).
// Expectations follow the build: stall-only by default, forwarding when REGREAD_FORWARD_EN.

module tb_regread_hazard_unit;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_COP0 = 6'b010000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] F_SLL   = 6'h00;
   localparam logic [5:0] F_JR    = 6'h08;
   localparam logic [5:0] F_ADD   = 6'h20;
   localparam logic [5:0] F_SUB   = 6'h22;
   localparam logic [5:0] F_NOR   = 6'h27;

`ifdef REGREAD_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   // Hand-derived for WB_STAGES=3.
   localparam int         RAW_STALLS = FWD ? 0 : 2;   // ALU producer -> immediate consumer
   localparam int         LU_STALLS  = FWD ? 1 : 2;   // LW producer -> immediate consumer
   localparam logic [3:0] SEL_S0     = FWD ? 4'd1 : 4'd0;
   localparam logic [3:0] SEL_S1     = FWD ? 4'd2 : 4'd0;
   localparam int         S_CUM      = 2 * RAW_STALLS + LU_STALLS;

   logic        clk, rst_n, id_valid, flush;
   logic [5:0]  id_op, id_funct;
   logic [4:0]  id_rs, id_rt, id_rd;

   logic        read_rs, read_rt, stall, issue;
   logic [3:0]  fwd_rs_sel, fwd_rt_sel, inflight_cnt;
   logic [15:0] stall_cnt;

   logic        s_read_rs, s_read_rt, s_stall, s_issue;
   logic [3:0]  s_fwd_rs_sel, s_fwd_rt_sel, s_inflight_cnt;
   logic [3:0]  s_stall_cnt;

   logic        o1_read_rs, o1_read_rt, o1_stall, o1_issue;
   logic [3:0]  o1_fwd_rs_sel, o1_fwd_rt_sel, o1_inflight_cnt;
   logic [15:0] o1_stall_cnt;

   regread_hazard_unit #(.WB_STAGES(3), .STALL_CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op), .id_funct(id_funct),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
      .read_rs(read_rs), .read_rt(read_rt), .stall(stall), .issue(issue),
      .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
      .inflight_cnt(inflight_cnt), .stall_cnt(stall_cnt));

   regread_hazard_unit #(.WB_STAGES(3), .STALL_CNT_W(4)) dut_sat (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op), .id_funct(id_funct),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
      .read_rs(s_read_rs), .read_rt(s_read_rt), .stall(s_stall), .issue(s_issue),
      .fwd_rs_sel(s_fwd_rs_sel), .fwd_rt_sel(s_fwd_rt_sel),
      .inflight_cnt(s_inflight_cnt), .stall_cnt(s_stall_cnt));

   regread_hazard_unit #(.WB_STAGES(1), .STALL_CNT_W(16)) dut_wb1 (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op), .id_funct(id_funct),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
      .read_rs(o1_read_rs), .read_rt(o1_read_rt), .stall(o1_stall), .issue(o1_issue),
      .fwd_rs_sel(o1_fwd_rs_sel), .fwd_rt_sel(o1_fwd_rt_sel),
      .inflight_cnt(o1_inflight_cnt), .stall_cnt(o1_stall_cnt));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_errors = 0;
   bit wb1_stall_seen = 1'b0;

   always @(negedge clk) begin
      if (rst_n && o1_stall) wb1_stall_seen = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_id(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      id_valid = v;
      id_op    = op;
      id_funct = fn;
      id_rs    = rs;
      id_rt    = rt;
      id_rd    = rd;
   endtask

   // Hold an instruction in ID until it issues; report stall cycles and the
   // forward selects seen in the issue cycle. Called #1 after a rising edge.
   task automatic run(input logic [5:0] op, input logic [5:0] fn,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      output int ns, output logic [3:0] srs, output logic [3:0] srt);
      bit done;
      done = 1'b0;
      ns   = 0;
      srs  = 4'd0;
      srt  = 4'd0;
      set_id(1'b1, op, fn, rs, rt, rd);
      for (int c = 0; c < 16 && !done; c++) begin
         @(negedge clk);
         if (issue) begin
            done = 1'b1;
            srs  = fwd_rs_sel;
            srt  = fwd_rt_sel;
         end else begin
            ns++;
         end
         @(posedge clk);
         #1;
      end
      id_valid = 1'b0;
      if (!done) check("issue_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain(input int n);
      id_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [5:0] op;
      logic [5:0] fn;
      logic [1:0] exp_rd;   // {read_rs, read_rt}
   } dec_vec_t;

   initial begin
      int         ns;
      logic [3:0] a, b;
      dec_vec_t   dv [10];

      // ---------------- reset with a valid instruction in ID
      rst_n = 1'b0;
      flush = 1'b0;
      set_id(1'b1, OP_R, F_ADD, 5'd2, 5'd3, 5'd1);
      repeat (2) @(posedge clk);
      #1;
      check("rst_stall",     32'(stall), 32'd0);
      check("rst_issue",     32'(issue), 32'd1);
      check("rst_inflight",  32'(inflight_cnt), 32'd0);
      check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      check("rst_sat_cnt",   32'(s_stall_cnt), 32'd0);
      check("rst_sel",       32'({fwd_rs_sel, fwd_rt_sel}), 32'd0);
      id_valid = 1'b0;
      rst_n    = 1'b1;
      @(posedge clk);
      #1;

      // ---------------- RAW: ADD $3,$1,$2 ; ADD $4,$3,$3
      run(OP_R, F_ADD, 5'd1, 5'd2, 5'd3, ns, a, b);
      check("raw_prod_stalls", ns, 0);
      check("raw_prod_inflight", 32'(inflight_cnt), 32'd1);
      run(OP_R, F_ADD, 5'd3, 5'd3, 5'd4, ns, a, b);
      check("raw_dep_stalls", ns, RAW_STALLS);
      check("raw_rs_sel", 32'(a), 32'(SEL_S0));
      check("raw_rt_sel", 32'(b), 32'(SEL_S0));
      check("raw_stall_cnt", 32'(stall_cnt), RAW_STALLS);
      drain(3);
      check("raw_drained", 32'(inflight_cnt), 32'd0);

      // ---------------- load-use: LW $5,0($1) ; ADDI $6,$5,1
      run(OP_LW, 6'd0, 5'd1, 5'd5, 5'd0, ns, a, b);
      check("lu_prod_stalls", ns, 0);
      run(OP_ADDI, 6'd0, 5'd5, 5'd6, 5'd0, ns, a, b);
      check("lu_dep_stalls", ns, LU_STALLS);
      check("lu_rs_sel", 32'(a), 32'(SEL_S1));
      check("lu_rt_sel", 32'(b), 32'd0);
      drain(3);

      // ---------------- ADD $7,$8,$9 ; SUB $10,$7,$7
      run(OP_R, F_ADD, 5'd8, 5'd9, 5'd7, ns, a, b);
      run(OP_R, F_SUB, 5'd7, 5'd7, 5'd10, ns, a, b);
      check("sub_dep_stalls", ns, RAW_STALLS);
      check("sub_rs_sel", 32'(a), 32'(SEL_S0));
      check("sub_rt_sel", 32'(b), 32'(SEL_S0));
      check("cum_stall_cnt", 32'(stall_cnt), S_CUM);
      drain(3);

      // ---------------- $0 destination is never recorded
      run(OP_ADDI, 6'd0, 5'd1, 5'd0, 5'd0, ns, a, b);
      check("r0_inflight", 32'(inflight_cnt), 32'd0);
      run(OP_R, F_ADD, 5'd0, 5'd0, 5'd1, ns, a, b);
      check("r0_dep_stalls", ns, 0);
      drain(3);

      // ---------------- SLL ignores rs
      run(OP_R, F_ADD, 5'd1, 5'd1, 5'd2, ns, a, b);
      run(OP_R, F_SLL, 5'd2, 5'd4, 5'd3, ns, a, b);
      check("sll_stalls", ns, 0);
      check("sll_rs_sel", 32'(a), 32'd0);
      drain(3);

      // ---------------- JR does not write rd
      run(OP_R, F_JR, 5'd1, 5'd0, 5'd5, ns, a, b);
      check("jr_inflight", 32'(inflight_cnt), 32'd0);
      run(OP_R, F_ADD, 5'd5, 5'd5, 5'd6, ns, a, b);
      check("jr_dep_stalls", ns, 0);
      drain(3);

      // ---------------- source-use decode table
      dv[0] = '{OP_SW,   6'd0,  2'b11};
      dv[1] = '{OP_COP0, 6'd0,  2'b01};
      dv[2] = '{OP_BEQ,  6'd0,  2'b11};
      dv[3] = '{OP_BNE,  6'd0,  2'b11};
      dv[4] = '{6'h3f,   6'd0,  2'b00};
      dv[5] = '{OP_R,    F_SLL, 2'b01};
      dv[6] = '{OP_R,    F_JR,  2'b10};
      dv[7] = '{OP_R,    F_NOR, 2'b11};
      dv[8] = '{OP_ORI,  6'd0,  2'b10};
      dv[9] = '{OP_R,    6'h3f, 2'b00};
      for (int i = 0; i < 10; i++) begin
         set_id(1'b0, dv[i].op, dv[i].fn, 5'd1, 5'd2, 5'd3);
         #1;
         check($sformatf("decode_%0d", i), 32'({read_rs, read_rt}), 32'(dv[i].exp_rd));
      end
      @(posedge clk);
      #1;

      // ---------------- flush kills ID and stage 0
      run(OP_LW, 6'd0, 5'd1, 5'd5, 5'd0, ns, a, b);
      check("fl_inflight_before", 32'(inflight_cnt), 32'd1);
      set_id(1'b1, OP_R, F_ADD, 5'd5, 5'd5, 5'd6);
      flush = 1'b1;
      @(negedge clk);
      check("fl_issue", 32'(issue), 32'd0);
      check("fl_stall", 32'(stall), 32'd0);
      @(posedge clk);
      #1;
      flush    = 1'b0;
      id_valid = 1'b0;
      check("fl_inflight_after", 32'(inflight_cnt), 32'd0);
      check("fl_stall_cnt", 32'(stall_cnt), S_CUM);
      run(OP_R, F_ADD, 5'd5, 5'd5, 5'd6, ns, a, b);
      check("fl_dep_stalls", ns, 0);
      drain(3);

      // ---------------- reset mid-operation discards in-flight entries
      run(OP_LW, 6'd0, 5'd1, 5'd5, 5'd0, ns, a, b);
      rst_n = 1'b0;
      #1;
      check("mid_rst_inflight", 32'(inflight_cnt), 32'd0);
      check("mid_rst_stall_cnt", 32'(stall_cnt), 32'd0);
      rst_n = 1'b1;
      run(OP_R, F_ADD, 5'd5, 5'd5, 5'd6, ns, a, b);
      check("mid_rst_dep_stalls", ns, 0);
      drain(3);

      // ---------------- stall counter saturation (4-bit instance)
      for (int p = 0; p < 14 / LU_STALLS; p++) begin
         run(OP_LW, 6'd0, 5'd1, 5'd5, 5'd0, ns, a, b);
         run(OP_R, F_ADD, 5'd5, 5'd5, 5'd6, ns, a, b);
      end
      check("sat_at_14", 32'(s_stall_cnt), 32'd14);
      check("main_at_14", 32'(stall_cnt), 32'd14);
      for (int p = 0; p < 6 / LU_STALLS; p++) begin
         run(OP_LW, 6'd0, 5'd1, 5'd5, 5'd0, ns, a, b);
         run(OP_R, F_ADD, 5'd5, 5'd5, 5'd6, ns, a, b);
      end
      check("sat_held_15", 32'(s_stall_cnt), 32'd15);
      check("main_at_20", 32'(stall_cnt), 32'd20);
      drain(3);

      check("wb1_never_stalls", 32'(wb1_stall_seen), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
